latch_en_gen: RTL and testbench

//   Upstream driver for the d_latch stage. Synchronises and debounces a raw switch

---
 rtl/latch_en_gen.sv | 84 ++++++++
 tb/tb_latch_en_gen.sv | 85 ++++++++
 2 files changed

// File: rtl/latch_en_gen.sv
// latch_en_gen: synchronise and debounce a raw input, then drive a latch with
// a stable data bit and a fixed-length enable window per committed change.
module latch_en_gen #(
   parameter int DB_CYCLES = 4,
   parameter int EN_CYCLES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic d,
   output logic en,
   output logic busy
);
   localparam int MX = (DB_CYCLES > EN_CYCLES) ? DB_CYCLES : EN_CYCLES;
   localparam int W = $clog2(MX) + 1;
   typedef enum logic [1:0] {IDLE, DEBOUNCE, ENABLE} state_t;
   state_t state, state_n;
   logic s1, din_s, stable, stable_n, d_n, en_n;
   logic [W-1:0] cnt, cnt_n, ecnt, ecnt_n;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1     <= 1'b0;
         din_s  <= 1'b0;
         state  <= IDLE;
         cnt    <= '0;
         ecnt   <= '0;
         stable <= 1'b0;
         d      <= 1'b0;
         en     <= 1'b0;
         busy   <= 1'b0;
      end else begin
         s1     <= din;
         din_s  <= s1;
         state  <= state_n;
         cnt    <= cnt_n;
         ecnt   <= ecnt_n;
         stable <= stable_n;
         d      <= d_n;
         en     <= en_n;
         busy   <= (state_n != IDLE);
      end
   end
   // d and stable move together, and only on the commit edge
   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      ecnt_n   = ecnt;
      stable_n = stable;
      d_n      = d;
      en_n     = en;
      case (state)
         IDLE: begin
            if (din_s != stable) begin
               state_n = DEBOUNCE;
               cnt_n   = W'(1);
            end
         end
         DEBOUNCE: begin
            if (din_s == stable) begin
               state_n = IDLE;
               cnt_n   = '0;
            end else if (cnt == W'(DB_CYCLES)) begin
               stable_n = din_s;
               d_n      = din_s;
               en_n     = 1'b1;
               ecnt_n   = W'(1);
               cnt_n    = '0;
               state_n  = ENABLE;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         ENABLE: begin
            if (ecnt == W'(EN_CYCLES)) begin
               en_n    = 1'b0;
               state_n = IDLE;
            end else begin
               ecnt_n = ecnt + 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end
endmodule

// File: tb/tb_latch_en_gen.sv
// tb_latch_en_gen: directed per-cycle vectors for latch_en_gen, plus a second
// instance with single-cycle debounce and enable.
module tb_latch_en_gen;
   typedef struct {
      logic       din;
      logic [2:0] exp;
      int         tid;
   } vec_t;
   logic clk = 1'b0;
   logic rst_n, din, d, en, busy;
   logic rst_n_b, din_b, d_b, en_b, busy_b;
   int checks = 0;
   int errors = 0;
   vec_t rows[$];
   latch_en_gen #(.DB_CYCLES(4), .EN_CYCLES(2)) dut_a (
      .clk(clk), .rst_n(rst_n), .din(din), .d(d), .en(en), .busy(busy)
   );
   latch_en_gen #(.DB_CYCLES(1), .EN_CYCLES(1)) dut_b (
      .clk(clk), .rst_n(rst_n_b), .din(din_b), .d(d_b), .en(en_b), .busy(busy_b)
   );
   always #5 clk = ~clk;
   task automatic check(input string nm, input logic [2:0] got, input logic [2:0] ex);
      checks++;
      if (got !== ex) begin
         errors++;
         $display("FAIL %s: {d,en,busy} got %b expected %b", nm, got, ex);
      end
   endtask
   task automatic add(input logic di, input logic [2:0] ex, input int n, input int tid);
      for (int i = 0; i < n; i++) rows.push_back('{di, ex, tid});
   endtask
   task automatic step(input logic di, input logic [2:0] ex, input string nm);
      din = di;
      @(posedge clk);
      #1;
      check(nm, {d, en, busy}, ex);
   endtask
   task automatic step_b(input logic di, input logic [2:0] ex, input string nm);
      din_b = di;
      @(posedge clk);
      #1;
      check(nm, {d_b, en_b, busy_b}, ex);
   endtask
   initial begin
      // Expected {d,en,busy} after each edge; din is the value applied before it
      add(1, 3'b000, 2, 1); add(1, 3'b001, 4, 1); add(1, 3'b111, 2, 1); add(1, 3'b100, 2, 1);
      add(0, 3'b100, 2, 2); add(0, 3'b101, 4, 2); add(0, 3'b011, 2, 2); add(0, 3'b000, 2, 2);
      add(1, 3'b000, 1, 3); add(0, 3'b000, 1, 3);
      for (int i = 0; i < 4; i++) begin
         add(1, 3'b001, 1, 3); add(0, 3'b000, 1, 3);
      end
      add(0, 3'b001, 1, 3); add(0, 3'b000, 3, 3);
      add(1, 3'b000, 2, 4); add(1, 3'b001, 4, 4); add(1, 3'b111, 1, 4); add(0, 3'b111, 1, 4);
      add(0, 3'b100, 1, 4); add(0, 3'b101, 4, 4); add(0, 3'b011, 2, 4); add(0, 3'b000, 1, 4);
      rst_n = 1'b0; din = 1'b1; rst_n_b = 1'b0; din_b = 1'b0;
      #1;
      check("reset_a", {d, en, busy}, 3'b000);
      check("reset_b", {d_b, en_b, busy_b}, 3'b000);
      repeat (2) @(posedge clk);
      #1;
      check("reset_held_a", {d, en, busy}, 3'b000);
      @(negedge clk);
      rst_n = 1'b1; rst_n_b = 1'b1;
      foreach (rows[i]) step(rows[i].din, rows[i].exp, $sformatf("t%0d_row%0d", rows[i].tid, i));
      step(1, 3'b000, "t5_sync0"); step(1, 3'b000, "t5_sync1");
      for (int i = 0; i < 4; i++) step(1, 3'b001, $sformatf("t5_deb%0d", i));
      step(1, 3'b111, "t5_window");
      #2;
      rst_n = 1'b0;
      #1;
      check("t5_async_rst", {d, en, busy}, 3'b000);
      repeat (2) @(posedge clk);
      #1;
      check("t5_rst_held", {d, en, busy}, 3'b000);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) step(rows[i].din, rows[i].exp, $sformatf("t5_recover%0d", i));
      check("t6_idle_b", {d_b, en_b, busy_b}, 3'b000);
      step_b(1, 3'b000, "t6_e1"); step_b(1, 3'b000, "t6_e2");
      step_b(1, 3'b001, "t6_deb"); step_b(1, 3'b111, "t6_window");
      step_b(1, 3'b100, "t6_after0"); step_b(1, 3'b100, "t6_after1");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
